// File: rtl/apb_ic_sched_pkg.sv
// Shared definitions for the cluster APB interconnect: scheduler state
// encoding and the width helper used to size derived parameters.
package apb_ic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // max(1, clog2(n)): an index or counter always needs at least one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin search: first requester above last_idx,
// wrapping to the lowest requester when none is found above it.
module apb_rr_pick
    import apb_ic_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int GB = clog2_min1(N)
) (
    input  logic [N-1:0]  reqs,
    input  logic [GB-1:0] last_idx,
    output logic [N-1:0]  next_oh,
    output logic [GB-1:0] next_idx,
    output logic          any
);

    logic          hi_found;
    logic          lo_found;
    logic [GB-1:0] hi_idx;
    logic [GB-1:0] lo_idx;

    // Scanning downward leaves the lowest match in each candidate slot.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (reqs[i]) begin
                lo_found = 1'b1;
                lo_idx   = GB'(i);
                if (i > int'(last_idx)) begin
                    hi_found = 1'b1;
                    hi_idx   = GB'(i);
                end
            end
        end
        any      = lo_found;
        next_idx = hi_found ? hi_idx : (lo_found ? lo_idx : last_idx);
        next_oh  = lo_found ? (N'(1) << next_idx) : '0;
    end

endmodule

// File: rtl/apb_ic_sched.sv
// Transfer-level scheduler for the shared APB slave bus: round-robin grant,
// SETUP/ACCESS phasing and an ACCESS-phase watchdog.
module apb_ic_sched
    import apb_ic_sched_pkg::*;
#(
    parameter int  NUM_MASTERS    = 4,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int GRANT_BITS     = clog2_min1(NUM_MASTERS),
    localparam int TO_BITS        = clog2_min1(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] reqs,
    input  logic                   slave_pready,
    output logic [NUM_MASTERS-1:0] grants,
    output logic [GRANT_BITS-1:0]  grant_idx,
    output logic                   m_psel,
    output logic                   m_penable,
    output logic                   s_pready,
    output logic                   xfer_done,
    output logic                   timeout_err,
    output state_t                 fsm_state
);

    // Handshake: a granted master keeps its req high until it sees s_pready
    // in ACCESS; dropping req before that abandons the transfer silently.

    localparam logic [GRANT_BITS-1:0] LAST_RST = GRANT_BITS'(NUM_MASTERS - 1);
    localparam logic [TO_BITS-1:0]    TO_LAST  =
        TO_BITS'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t                  state, state_n;
    logic [NUM_MASTERS-1:0]  grants_n;
    logic [GRANT_BITS-1:0]   last_idx, last_n;
    logic [TO_BITS-1:0]      to_cnt, cnt_n;

    logic [NUM_MASTERS-1:0]  pick_oh;
    logic [GRANT_BITS-1:0]   pick_idx;
    logic                    pick_any;
    logic                    granted_req;

    apb_rr_pick #(
        .N  (NUM_MASTERS),
        .GB (GRANT_BITS)
    ) u_pick (
        .reqs     (reqs),
        .last_idx (last_idx),
        .next_oh  (pick_oh),
        .next_idx (pick_idx),
        .any      (pick_any)
    );

    assign granted_req = |(reqs & grants);
    assign grant_idx   = last_idx;
    assign fsm_state   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grants   <= '0;
            last_idx <= LAST_RST;
            to_cnt   <= '0;
        end else begin
            state    <= state_n;
            grants   <= grants_n;
            last_idx <= last_n;
            to_cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        grants_n    = grants;
        last_n      = last_idx;
        cnt_n       = to_cnt;
        m_psel      = 1'b0;
        m_penable   = 1'b0;
        s_pready    = 1'b0;
        xfer_done   = 1'b0;
        timeout_err = 1'b0;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grants_n = pick_oh;
                    last_n   = pick_idx;
                    state_n  = SETUP;
                end else begin
                    grants_n = '0;
                end
            end

            SETUP: begin
                m_psel = 1'b1;
                if (!granted_req) begin
                    grants_n = '0;
                    state_n  = IDLE;
                end else begin
                    cnt_n   = '0;
                    state_n = ACCESS;
                end
            end

            ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
                // PREADY wins over both an abort and watchdog expiry.
                if (slave_pready) begin
                    s_pready  = 1'b1;
                    xfer_done = 1'b1;
                    grants_n  = '0;
                    state_n   = IDLE;
                end else if (!granted_req) begin
                    grants_n = '0;
                    state_n  = IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (to_cnt == TO_LAST)) begin
                    s_pready    = 1'b1;
                    timeout_err = 1'b1;
                    grants_n    = '0;
                    state_n     = IDLE;
                end else begin
                    cnt_n = (TIMEOUT_CYCLES > 0) ? (to_cnt + TO_BITS'(1)) : '0;
                end
            end

            default: begin
                grants_n = '0;
                state_n  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_ic_sched.sv
// Directed-vector bench for apb_ic_sched with a 4-cycle watchdog.
module tb_apb_ic_sched;
    import apb_ic_sched_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] reqs;
    logic       slave_pready;
    logic [3:0] grants;
    logic [1:0] grant_idx;
    logic       m_psel;
    logic       m_penable;
    logic       s_pready;
    logic       xfer_done;
    logic       timeout_err;
    state_t     fsm_state;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    apb_ic_sched #(
        .NUM_MASTERS    (4),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reqs         (reqs),
        .slave_pready (slave_pready),
        .grants       (grants),
        .grant_idx    (grant_idx),
        .m_psel       (m_psel),
        .m_penable    (m_penable),
        .s_pready     (s_pready),
        .xfer_done    (xfer_done),
        .timeout_err  (timeout_err),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=hang exp=finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Packed view: {grants, grant_idx, psel, penable, s_pready, xfer_done, timeout_err}
    function automatic logic [31:0] ev(input logic [3:0] g, input logic [1:0] idx,
                                       input logic ps, input logic pe, input logic sr,
                                       input logic dn, input logic te);
        return 32'({g, idx, ps, pe, sr, dn, te});
    endfunction

    function automatic logic [31:0] obs();
        return 32'({grants, grant_idx, m_psel, m_penable, s_pready, xfer_done, timeout_err});
    endfunction

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; checks follow 3 units later.
    task automatic drive(input logic [3:0] r, input logic p);
        @(posedge clk);
        #1;
        reqs         = r;
        slave_pready = p;
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        reqs         = 4'b0000;
        slave_pready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] e;
        logic [3:0] oh;

        reset        = 1'b1;
        reqs         = 4'b0000;
        slave_pready = 1'b0;
        #12;
        chk("reset_outputs", obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        chk("reset_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single master, PREADY on the third ACCESS cycle.
        drive(4'b0001, 0); chk("t1_idle",    obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        drive(4'b0001, 0); chk("t1_setup",   obs(), ev(4'b0001, 2'd0, 1, 0, 0, 0, 0));
        drive(4'b0001, 0); chk("t1_acc1",    obs(), ev(4'b0001, 2'd0, 1, 1, 0, 0, 0));
        chk("t1_acc1_state", 32'(fsm_state), 32'(ACCESS));
        drive(4'b0001, 0); chk("t1_acc2",    obs(), ev(4'b0001, 2'd0, 1, 1, 0, 0, 0));
        drive(4'b0001, 1); chk("t1_acc3",    obs(), ev(4'b0001, 2'd0, 1, 1, 1, 1, 0));
        drive(4'b0000, 0); chk("t1_turn",    obs(), ev(4'b0000, 2'd0, 0, 0, 0, 0, 0));

        // All masters requesting, PREADY immediately: order 0,1,2,3,0.
        do_reset();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        drive(4'b1111, 1); chk("t2_idle0", obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e;
            drive(4'b1111, 1);
            chk($sformatf("t2_setup%0d", k), obs(), ev(oh, e, 1, 0, 0, 0, 0));
            drive(4'b1111, 1);
            chk($sformatf("t2_acc%0d", k), obs(), ev(oh, e, 1, 1, 1, 1, 0));
            drive((k == 4) ? 4'b0000 : 4'b1111, 1);
            chk($sformatf("t2_gap%0d", k), obs(), ev(4'b0000, e, 0, 0, 0, 0, 0));
        end

        // Fairness: make last_idx=1, then reqs=1001 must pick master 3.
        drive(4'b0010, 1); chk("t3_idle",  obs(), ev(4'b0000, 2'd0, 0, 0, 0, 0, 0));
        drive(4'b0010, 1); chk("t3_set1",  obs(), ev(4'b0010, 2'd1, 1, 0, 0, 0, 0));
        drive(4'b0010, 1); chk("t3_acc1",  obs(), ev(4'b0010, 2'd1, 1, 1, 1, 1, 0));
        drive(4'b1001, 0); chk("t3_gap1",  obs(), ev(4'b0000, 2'd1, 0, 0, 0, 0, 0));
        drive(4'b1001, 0); chk("t3_set3",  obs(), ev(4'b1000, 2'd3, 1, 0, 0, 0, 0));
        drive(4'b1101, 0); chk("t3_lock_a", obs(), ev(4'b1000, 2'd3, 1, 1, 0, 0, 0));
        drive(4'b1101, 1); chk("t3_lock_b", obs(), ev(4'b1000, 2'd3, 1, 1, 1, 1, 0));
        drive(4'b0101, 0); chk("t3_gap3",  obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        drive(4'b0101, 1); chk("t3_set0",  obs(), ev(4'b0001, 2'd0, 1, 0, 0, 0, 0));
        drive(4'b0101, 1); chk("t3_acc0",  obs(), ev(4'b0001, 2'd0, 1, 1, 1, 1, 0));
        drive(4'b0000, 0); chk("t3_gap0",  obs(), ev(4'b0000, 2'd0, 0, 0, 0, 0, 0));

        // Watchdog expiry after 4 ACCESS cycles with PREADY held low.
        drive(4'b0100, 0); chk("t4_idle",  obs(), ev(4'b0000, 2'd0, 0, 0, 0, 0, 0));
        drive(4'b0100, 0); chk("t4_setup", obs(), ev(4'b0100, 2'd2, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 0);
            chk($sformatf("t4_wait%0d", k), obs(), ev(4'b0100, 2'd2, 1, 1, 0, 0, 0));
        end
        drive(4'b0100, 0); chk("t4_expire", obs(), ev(4'b0100, 2'd2, 1, 1, 1, 0, 1));
        drive(4'b0000, 0); chk("t4_after",  obs(), ev(4'b0000, 2'd2, 0, 0, 0, 0, 0));
        chk("t4_after_state", 32'(fsm_state), 32'(IDLE));

        // PREADY on the expiry cycle is a normal completion.
        drive(4'b0100, 0); chk("t4b_idle",  obs(), ev(4'b0000, 2'd2, 0, 0, 0, 0, 0));
        drive(4'b0100, 0); chk("t4b_setup", obs(), ev(4'b0100, 2'd2, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 0);
            chk($sformatf("t4b_wait%0d", k), obs(), ev(4'b0100, 2'd2, 1, 1, 0, 0, 0));
        end
        drive(4'b0100, 1); chk("t4b_ready", obs(), ev(4'b0100, 2'd2, 1, 1, 1, 1, 0));
        drive(4'b0000, 0); chk("t4b_after", obs(), ev(4'b0000, 2'd2, 0, 0, 0, 0, 0));

        // Abort in SETUP, then in ACCESS.
        drive(4'b1000, 0); chk("t5_idle",    obs(), ev(4'b0000, 2'd2, 0, 0, 0, 0, 0));
        drive(4'b0000, 0); chk("t5_setup3",  obs(), ev(4'b1000, 2'd3, 1, 0, 0, 0, 0));
        drive(4'b0001, 0); chk("t5_abort_s", obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        drive(4'b0001, 0); chk("t5_setup0",  obs(), ev(4'b0001, 2'd0, 1, 0, 0, 0, 0));
        drive(4'b0000, 0); chk("t5_acc0",    obs(), ev(4'b0001, 2'd0, 1, 1, 0, 0, 0));
        drive(4'b0010, 0); chk("t5_abort_a", obs(), ev(4'b0000, 2'd0, 0, 0, 0, 0, 0));
        drive(4'b0010, 0); chk("t5_setup1",  obs(), ev(4'b0010, 2'd1, 1, 0, 0, 0, 0));
        drive(4'b0010, 0); chk("t6_acc1",    obs(), ev(4'b0010, 2'd1, 1, 1, 0, 0, 0));

        // Asynchronous reset between edges while in ACCESS.
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async_rst", obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        chk("t6_async_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        reqs  = 4'b0000;
        drive(4'b0110, 0); chk("t6_idle",   obs(), ev(4'b0000, 2'd3, 0, 0, 0, 0, 0));
        drive(4'b0110, 0); chk("t6_setup1", obs(), ev(4'b0010, 2'd1, 1, 0, 0, 0, 0));
        drive(4'b0000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_ic_sched.md
Name: apb_ic_sched

Overview:
- Transfer-level scheduler for the shared APB slave bus inside the cluster interconnect.
- Arbitrates master PSEL requests round-robin and locks the grant for one complete APB transfer.
- Generates clean SETUP/ACCESS phasing (PSEL, then PENABLE) toward the decoded slave port.
- Aborts stalled transfers with a watchdog. The interconnect muxes master signals using grant_idx and gates slave-side PSEL/PENABLE with m_psel/m_penable.

Parameters:
- NUM_MASTERS, 4, number of requesting APB masters (>=1).
- TIMEOUT_CYCLES, 64, max ACCESS-phase cycles before forced abort; 0 disables the watchdog.
- GRANT_BITS, max(1,clog2(NUM_MASTERS)), derived width of grant_idx; do not set.
- TO_BITS, max(1,clog2(TIMEOUT_CYCLES+1)), derived counter width; do not set.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reqs  in  NUM_MASTERS  per-master PSEL request.
- slave_pready  in  1  PREADY of the currently addressed slave (already demuxed).
- grants  out  NUM_MASTERS  one-hot grant, all-zero when idle.
- grant_idx  out  GRANT_BITS  binary index of the granted master (last granted when idle).
- m_psel  out  1  enable for slave-side PSEL; high in SETUP and ACCESS.
- m_penable  out  1  slave-side PENABLE; high only in ACCESS.
- s_pready  out  1  PREADY returned to the granted master: slave_pready in ACCESS, or the forced timeout pulse.
- xfer_done  out  1  one-cycle pulse on normal completion (ACCESS & slave_pready).
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a transfer.

Behaviour:
- Reset (async): state=IDLE, grants=0, last_idx=NUM_MASTERS-1 (so master 0 wins first), timeout counter=0. All outputs are 0 except grant_idx, which equals last_idx.
- States: IDLE, SETUP, ACCESS. grants, grant_idx and state are registered. m_psel, m_penable, s_pready, xfer_done and timeout_err decode combinationally from state and inputs.
- IDLE:
  - If reqs!=0, pick the first set bit searching from last_idx+1 upward, wrapping modulo NUM_MASTERS.
  - Register the one-hot grant, update last_idx, go to SETUP.
  - With no request, stay in IDLE with grants=0.
- SETUP:
  - m_psel=1, m_penable=0, lasting exactly one cycle; then go to ACCESS.
  - If the granted req bit is low, abort to IDLE with grants=0 and no pulse.
- ACCESS:
  - m_psel=1, m_penable=1, s_pready=slave_pready.
  - slave_pready=1: xfer_done=1 that cycle; next state IDLE with grants cleared. A mandatory idle turnaround cycle follows, so minimum transfer is 3 cycles and back-to-back grants are 3 cycles apart.
  - Granted req bit drops without PREADY: abort to IDLE, no pulses.
  - Watchdog (TIMEOUT_CYCLES>0):
    - Counter clears on SETUP->ACCESS and increments each ACCESS cycle without PREADY.
    - When the counter equals TIMEOUT_CYCLES-1 and slave_pready=0: s_pready=1 (forced) and timeout_err=1; next state IDLE.
    - PREADY in the same cycle as expiry takes priority: a normal completion, with no timeout_err.
- Grant is locked for the whole transfer. Requests from other masters never preempt it.
- With NUM_MASTERS=1 the search degenerates to master 0; grant_idx is 0.
- Simultaneous reset and any event: reset wins. Reset mid-ACCESS drops m_psel/m_penable immediately and produces no pulse.
- Counter saturation is impossible because expiry leaves ACCESS.
- Outputs never carry X after reset.

Decomposition:
- A shared interconnect package holds the state encoding constants (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the max(1,clog2()) width helper. The GRANT_BITS/TO_BITS derivations use that helper.
- The round-robin next-master search is a natural sub-module: apb_rr_pick.
  - Inputs: reqs, last_idx.
  - Outputs: next one-hot, next_idx, any.
  - Purely combinational, reusable by other interconnect arbiters.

Test Plan:
- Single master: reqs=0001, slave_pready rises 2 cycles after m_penable.
  - grants=0001 for SETUP+3 ACCESS cycles.
  - xfer_done pulses once, then 1 idle cycle.
- Simultaneous requests: reqs=1111 held, each completes with PREADY on the first ACCESS cycle.
  - Grant order is 0,1,2,3,0.
  - Each grant spans 2 cycles, separated by 1 idle cycle.
- Fairness: last_idx=1, reqs=1001.
  - Master 3 is granted before master 0.
  - A master-2 request raised mid-transfer does not change grants until IDLE.
- Timeout: TIMEOUT_CYCLES=4, slave_pready held 0.
  - Exactly 4 ACCESS cycles.
  - On the 4th: s_pready=1, timeout_err=1, xfer_done=0.
  - Then IDLE. Repeat with PREADY on the 4th cycle: xfer_done=1, timeout_err=0.
- Abort: the granted master drops its req during SETUP, and again during ACCESS.
  - IDLE the next cycle, grants=0, no pulses.
  - The next requester is granted per round-robin.
- Async reset asserted mid-ACCESS between clock edges.
  - m_psel, m_penable and grants go 0 without waiting for a clock edge.
  - After release with reqs=0110, master 1 is granted first.
